// File: rtl/index_mask_builder_if.sv
// Index-beat input and mask/count output handshake bundle for index_mask_builder.
// The master drives index beats and downstream ready; the slave (the builder) returns the mask stage.
interface index_mask_builder_if #(
  parameter int unsigned DATA_WD = 8,
  parameter int unsigned IND_WD  = $clog2(DATA_WD),
  parameter int unsigned CNT_WD  = $clog2(DATA_WD + 1)
);
  logic                i_valid;
  logic [IND_WD-1:0]   i_index;
  logic                i_last;
  logic                o_ready;
  logic                o_valid;
  logic [DATA_WD-1:0]  o_mask;
  logic [CNT_WD-1:0]   o_count;
  logic                o_dup;
  logic                i_ready;

  modport master (
    output i_valid, i_index, i_last, i_ready,
    input  o_ready, o_valid, o_mask, o_count, o_dup
  );

  modport slave (
    input  i_valid, i_index, i_last, i_ready,
    output o_ready, o_valid, o_mask, o_count, o_dup
  );
endinterface

// File: rtl/index_mask_builder.sv
// Rebuilds a DATA_WD-bit mask from a frame of index beats; presents mask and popcount on a registered output stage.
// Define DUP_DETECT_EN to flag frames that repeat an index on o_dup; otherwise o_dup is tied low.
module index_mask_builder #(
  parameter int unsigned DATA_WD = 8,
  parameter int unsigned IND_WD  = $clog2(DATA_WD),
  parameter int unsigned CNT_WD  = $clog2(DATA_WD + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  index_mask_builder_if.slave bus
);

  logic [IND_WD-1:0]  idx;
  logic [DATA_WD-1:0] sel;
  logic [DATA_WD-1:0] merged;
  logic [CNT_WD-1:0]  pop;
  logic               ready;
  logic               accept;

  logic [DATA_WD-1:0] acc_q,   acc_d;
  logic [DATA_WD-1:0] mask_q,  mask_d;
  logic [CNT_WD-1:0]  count_q, count_d;
  logic               valid_q, valid_d;

  assign idx    = bus.i_index;
  assign ready  = ~valid_q | bus.i_ready;
  assign accept = bus.i_valid & ready;

  // Out-of-range indices (only possible for non power-of-2 widths) contribute nothing.
  always_comb begin
    sel = '0;
    if (32'(idx) < DATA_WD) sel[idx] = 1'b1;
  end

  always_comb begin
    merged = acc_q | sel;
    pop    = '0;
    for (int unsigned b = 0; b < DATA_WD; b++) pop = pop + CNT_WD'(merged[b]);
  end

  always_comb begin
    acc_d   = acc_q;
    mask_d  = mask_q;
    count_d = count_q;
    valid_d = valid_q;
    if (valid_q && bus.i_ready) valid_d = 1'b0;
    if (accept) begin
      if (bus.i_last) begin
        mask_d  = merged;
        count_d = pop;
        valid_d = 1'b1;
        acc_d   = '0;
      end else begin
        acc_d   = merged;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q   <= '0;
      mask_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

`ifdef DUP_DETECT_EN
  logic hit;
  logic flag_q, flag_d;
  logic dup_q,  dup_d;

  assign hit = |(acc_q & sel);

  // Flag accumulates across the frame; folded into o_dup on the last beat and then cleared.
  always_comb begin
    flag_d = flag_q;
    dup_d  = dup_q;
    if (accept) begin
      if (bus.i_last) begin
        dup_d  = flag_q | hit;
        flag_d = 1'b0;
      end else begin
        flag_d = flag_q | hit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      flag_q <= 1'b0;
      dup_q  <= 1'b0;
    end else begin
      flag_q <= flag_d;
      dup_q  <= dup_d;
    end
  end

  assign bus.o_dup = dup_q;
`else
  assign bus.o_dup = 1'b0;
`endif

  assign bus.o_ready = ready;
  assign bus.o_valid = valid_q;
  assign bus.o_mask  = mask_q;
  assign bus.o_count = count_q;

endmodule

// File: tb/tb_index_mask_builder.sv
// Randomized and directed bench for index_mask_builder against a frame-list reference model.
// Honours DUP_DETECT_EN the same way as the design build.
module tb_index_mask_builder;
  localparam int unsigned DATA_WD = 8;
  localparam int unsigned IND_WD  = $clog2(DATA_WD);
  localparam int unsigned CNT_WD  = $clog2(DATA_WD + 1);

  logic clk;
  logic reset_n;

  index_mask_builder_if #(.DATA_WD(DATA_WD), .IND_WD(IND_WD), .CNT_WD(CNT_WD)) bus ();

  index_mask_builder #(.DATA_WD(DATA_WD), .IND_WD(IND_WD), .CNT_WD(CNT_WD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  // Reference model: list of indices seen in the current frame plus the presented output.
  int          frame_q[$];
  bit          exp_valid;
  int unsigned exp_mask;
  int unsigned exp_count;
  bit          exp_dup;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    frame_q.delete();
    exp_valid = 1'b0;
    exp_mask  = 0;
    exp_count = 0;
    exp_dup   = 1'b0;
  endtask

  // Close a frame: mask is the set of in-range indices, count its cardinality, dup any repeat.
  task automatic model_finish_frame();
    bit seen [DATA_WD];
    bit rep;
    int unsigned m;
    int unsigned c;
    m = 0; c = 0; rep = 1'b0;
    foreach (seen[k]) seen[k] = 1'b0;
    foreach (frame_q[k]) begin
      if (frame_q[k] < int'(DATA_WD)) begin
        if (seen[frame_q[k]]) rep = 1'b1;
        else begin
          seen[frame_q[k]] = 1'b1;
          m = m + (32'd1 << frame_q[k]);
          c++;
        end
      end
    end
    exp_mask  = m;
    exp_count = c;
`ifdef DUP_DETECT_EN
    exp_dup   = rep;
`else
    exp_dup   = 1'b0;
`endif
    exp_valid = 1'b1;
    frame_q.delete();
  endtask

  task automatic compare_outputs(input string tag);
    check_eq({tag, ".o_valid"}, 32'(bus.o_valid), 32'(exp_valid));
    check_eq({tag, ".o_mask"},  32'(bus.o_mask),  exp_mask);
    check_eq({tag, ".o_count"}, 32'(bus.o_count), exp_count);
    check_eq({tag, ".o_dup"},   32'(bus.o_dup),   32'(exp_dup));
  endtask

  // Called just after a falling edge: drive, check ready, clock, update model, compare.
  task automatic step(input bit v, input int idx, input bit l, input bit r, input string tag);
    bit exp_ready;
    bus.i_valid = v;
    bus.i_index = IND_WD'(idx);
    bus.i_last  = l;
    bus.i_ready = r;
    exp_ready = !exp_valid || r;
    #1;
    check_eq({tag, ".o_ready"}, 32'(bus.o_ready), 32'(exp_ready));
    @(posedge clk);
    if (exp_valid && r) exp_valid = 1'b0;
    if (v && exp_ready) begin
      frame_q.push_back(idx);
      if (l) model_finish_frame();
    end
    @(negedge clk);
    compare_outputs(tag);
  endtask

  task automatic do_reset(input int cycles);
    reset_n     = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_index = '0;
    bus.i_last  = 1'b0;
    bus.i_ready = 1'b0;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();
    compare_outputs("reset");
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    model_clear();
    reset_n     = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_index = '0;
    bus.i_last  = 1'b0;
    bus.i_ready = 1'b0;
    @(negedge clk);

    do_reset(2);
    bus.i_ready = 1'b1;
    #1;
    check_eq("reset.o_ready", 32'(bus.o_ready), 32'd1);
    check_eq("reset.o_mask_lit", 32'(bus.o_mask), 32'h00);
    @(negedge clk);

    // Beats 1, 4, 6(last)
    step(1, 1, 0, 1, "f152.b0");
    step(1, 4, 0, 1, "f152.b1");
    step(1, 6, 1, 1, "f152.b2");
    check_eq("f152.mask_lit",  32'(bus.o_mask),  32'h52);
    check_eq("f152.count_lit", 32'(bus.o_count), 32'd3);
    check_eq("f152.valid_lit", 32'(bus.o_valid), 32'd1);
    step(0, 0, 0, 1, "f152.drain");
    check_eq("f152.drop_lit", 32'(bus.o_valid), 32'd0);

    // Single-beat frame
    step(1, 7, 1, 1, "f80");
    check_eq("f80.mask_lit",  32'(bus.o_mask),  32'h80);
    check_eq("f80.count_lit", 32'(bus.o_count), 32'd1);

    // Repeated index
    step(1, 3, 0, 1, "f09.b0");
    step(1, 3, 0, 1, "f09.b1");
    step(1, 0, 1, 1, "f09.b2");
    check_eq("f09.mask_lit",  32'(bus.o_mask),  32'h09);
    check_eq("f09.count_lit", 32'(bus.o_count), 32'd2);
`ifdef DUP_DETECT_EN
    check_eq("f09.dup_lit", 32'(bus.o_dup), 32'd1);
`else
    check_eq("f09.dup_lit", 32'(bus.o_dup), 32'd0);
`endif
    step(0, 0, 0, 1, "f09.drain");

    // Output stall then back-to-back reload
    step(1, 2, 1, 0, "stall.load");
    for (int k = 0; k < 3; k++) begin
      step(1, 6, 0, 0, "stall.hold");
      check_eq("stall.ready_lit", 32'(bus.o_ready), 32'd0);
      check_eq("stall.mask_lit",  32'(bus.o_mask),  32'h04);
    end
    step(1, 5, 1, 1, "stall.reload");
    check_eq("reload.valid_lit", 32'(bus.o_valid), 32'd1);
    check_eq("reload.mask_lit",  32'(bus.o_mask),  32'h20);
    step(0, 0, 0, 1, "reload.drain");

    // Partial frame discarded by reset
    step(1, 0, 0, 1, "part.b0");
    step(1, 1, 0, 1, "part.b1");
    do_reset(1);
    step(1, 2, 1, 1, "part.after");
    check_eq("part.mask_lit", 32'(bus.o_mask), 32'h04);

    // Reset with a pending output
    step(1, 5, 1, 0, "pend.load");
    do_reset(1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 9) < 7), int'($urandom_range(0, DATA_WD - 1)),
           ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 7), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
